// File: rtl/hazard_scoreboard_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_hazard_pkg                                                     |
// | Shared register-address types and constants for hazard control.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package riscv_hazard_pkg;
  localparam int REG_ADDR_W      = 5;
  localparam int NUM_REGS        = 32;
  localparam int FWD_SEL_REGFILE = 0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_scoreboard_unit_if                                            |
// | ID/EX hazard inputs and stall/forward-select outputs.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface hazard_scoreboard_unit_if #(
  parameter int NUM_SRC         = 2,
  parameter int FWD_STAGES      = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 32
);
  import riscv_hazard_pkg::*;

  localparam int SEL_W  = $clog2(FWD_STAGES + 1);
  localparam int PCNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic                                id_valid;
  reg_addr_t [NUM_SRC-1:0]             id_rs;
  reg_addr_t                           id_rd;
  logic                                id_reg_write;
  logic                                id_long;
  logic                                ex_mem_read;
  logic                                ex_reg_write;
  reg_addr_t                           ex_rd;
  reg_addr_t [NUM_SRC-1:0]             ex_rs;
  logic      [FWD_STAGES-1:0]          stg_reg_write;
  reg_addr_t [FWD_STAGES-1:0]          stg_rd;
  logic                                lr_done;
  reg_addr_t                           lr_rd;
  logic                                stall;
  logic      [NUM_SRC-1:0][SEL_W-1:0]  fwd_sel;
  logic      [PCNT_W-1:0]              pending_count;
  logic      [CNT_W-1:0]               stall_cycles;

  modport master (
    output id_valid, id_rs, id_rd, id_reg_write, id_long,
           ex_mem_read, ex_reg_write, ex_rd, ex_rs,
           stg_reg_write, stg_rd, lr_done, lr_rd,
    input  stall, fwd_sel, pending_count, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs, id_rd, id_reg_write, id_long,
           ex_mem_read, ex_reg_write, ex_rd, ex_rs,
           stg_reg_write, stg_rd, lr_done, lr_rd,
    output stall, fwd_sel, pending_count, stall_cycles
  );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard_unit_fwd.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | operand_forward_select                                               |
// | Priority encoder: youngest writing stage whose rd matches rs wins.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module operand_forward_select
  import riscv_hazard_pkg::*;
#(
  parameter int FWD_STAGES = 2,
  parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
  input  reg_addr_t                  rs,
  input  logic      [FWD_STAGES-1:0] stg_reg_write,
  input  reg_addr_t [FWD_STAGES-1:0] stg_rd,
  output logic      [SEL_W-1:0]      sel
);
  // Scan oldest to youngest so the lowest matching index is written last.
  always_comb begin
    sel = SEL_W'(FWD_SEL_REGFILE);
    for (int i = FWD_STAGES - 1; i >= 0; i--) begin
      if (stg_reg_write[i] && (stg_rd[i] != '0) && (stg_rd[i] == rs)) begin
        sel = SEL_W'(i + 1);
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_scoreboard_unit                                               |
// | Load-use/RAW/WAW/capacity stall, long-op scoreboard, forward selects.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hazard_scoreboard_unit
  import riscv_hazard_pkg::*;
#(
  parameter int NUM_SRC         = 2,
  parameter int FWD_STAGES      = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 32
) (
  input logic                    clk,
  input logic                    rst,
  hazard_scoreboard_unit_if.slave bus
);
  localparam int SEL_W  = $clog2(FWD_STAGES + 1);
  localparam int PCNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_REGS-1:0] pending;
  logic [PCNT_W-1:0]   pending_count;
  logic [CNT_W-1:0]    stall_cycles;

  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] pend_eff;
  logic [NUM_REGS-1:0] pending_next;
  logic [PCNT_W-1:0]   count_eff;
  logic                retire;
  logic                load_use;
  logic                raw;
  logic                waw;
  logic                cap;
  logic                stall;
  logic                fire;

  always_comb begin
    clr_mask = '0;
    if (bus.lr_done) clr_mask[bus.lr_rd] = 1'b1;
    // Regfile is write-before-read, so a same-cycle completion already resolves the hazard.
    pend_eff  = pending & ~clr_mask;
    retire    = bus.lr_done & pending[bus.lr_rd];
    count_eff = pending_count - PCNT_W'(retire);

    load_use = 1'b0;
    raw      = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (bus.ex_mem_read && bus.ex_reg_write && (bus.ex_rd != '0) &&
          (bus.ex_rd == bus.id_rs[s])) load_use = 1'b1;
      if (pend_eff[bus.id_rs[s]]) raw = 1'b1;
    end
    waw = bus.id_reg_write & pend_eff[bus.id_rd];
    cap = bus.id_long & bus.id_reg_write & (bus.id_rd != '0) &
          (count_eff == PCNT_W'(MAX_OUTSTANDING));

    stall = bus.id_valid & (load_use | raw | waw | cap);
    fire  = bus.id_valid & ~stall & bus.id_long & bus.id_reg_write & (bus.id_rd != '0);

    set_mask = '0;
    if (fire) set_mask[bus.id_rd] = 1'b1;
    // Set is applied after clear so a same-register reissue stays pending.
    pending_next = (pending & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending       <= '0;
      pending_count <= '0;
      stall_cycles  <= '0;
    end else begin
      pending       <= {pending_next[NUM_REGS-1:1], 1'b0};
      pending_count <= pending_count + PCNT_W'(fire) - PCNT_W'(retire);
      if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_fwd
    operand_forward_select #(
      .FWD_STAGES (FWD_STAGES),
      .SEL_W      (SEL_W)
    ) u_sel (
      .rs            (bus.ex_rs[s]),
      .stg_reg_write (bus.stg_reg_write),
      .stg_rd        (bus.stg_rd),
      .sel           (bus.fwd_sel[s])
    );
  end

  assign bus.stall         = stall;
  assign bus.pending_count = pending_count;
  assign bus.stall_cycles  = stall_cycles;
endmodule
`default_nettype wire
